axi2ahb_rdata: RTL and testbench

AXI2AHB_RDATA -- requirements
Module: axi2ahb_rdata

---
 rtl/axi2ahb_rdata_if.sv | 48 ++++
 rtl/axi2ahb_rdata.sv | 118 +++++++++++
 tb/tb_axi2ahb_rdata.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi2ahb_rdata_if.sv
// axi2ahb_rdata_if
// Bundles the read-data path of the AXI-to-AHB bridge into one interface:
// the AXI R channel, the AHB read data-phase inputs and the sideband
// signals exchanged with the bridge control block.
//   AXI R   : RDATA, RID, RRESP, RLAST, RVALID (to master), RREADY (from master)
//   AHB     : HRDATA, HREADY, HRESP (read data phase)
//   control : cmd_id_i, cmd_error_i, ctrl_rdata_valid_i, ctrl_rdata_last_i,
//             ctrl_rdata_ready_o (credit back), overflow_o (drop pulse)
// The slave modport is the read-data block's view; the master modport is the
// view of whatever drives it (the surrounding bridge, or a testbench).
interface axi2ahb_rdata_if #(
  parameter int AXI_ID_WIDTH   = 1,
  parameter int AXI_DATA_WIDTH = 32
);
  logic [AXI_DATA_WIDTH-1:0] RDATA;
  logic [AXI_ID_WIDTH-1:0]   RID;
  logic [1:0]                RRESP;
  logic                      RLAST;
  logic                      RVALID;
  logic                      RREADY;

  logic [AXI_DATA_WIDTH-1:0] HRDATA;
  logic                      HREADY;
  logic                      HRESP;

  logic [AXI_ID_WIDTH-1:0]   cmd_id_i;
  logic                      cmd_error_i;
  logic                      ctrl_rdata_valid_i;
  logic                      ctrl_rdata_last_i;
  logic                      ctrl_rdata_ready_o;
  logic                      overflow_o;

  modport slave (
    output RDATA, RID, RRESP, RLAST, RVALID,
    input  RREADY,
    input  HRDATA, HREADY, HRESP,
    input  cmd_id_i, cmd_error_i, ctrl_rdata_valid_i, ctrl_rdata_last_i,
    output ctrl_rdata_ready_o, overflow_o
  );

  modport master (
    input  RDATA, RID, RRESP, RLAST, RVALID,
    output RREADY,
    output HRDATA, HREADY, HRESP,
    output cmd_id_i, cmd_error_i, ctrl_rdata_valid_i, ctrl_rdata_last_i,
    input  ctrl_rdata_ready_o, overflow_o
  );
endinterface

// File: rtl/axi2ahb_rdata.sv
// axi2ahb_rdata
// Read-data return path of the AXI-to-AHB bridge. Every completed AHB read
// data phase (or a beat of a burst the control block rejected) is captured
// into a circular beat buffer and replayed on the AXI R channel in capture
// order. Once a beat of a burst errors, the rest of that burst reports SLVERR.
// Ports:
//   ACLK    - single clock, rising edge
//   ARESETN - asynchronous active-low reset, empties the buffer
//   bus     - axi2ahb_rdata_if.slave: AXI R channel, AHB read data phase,
//             control-block sideband (credit and overflow pulse)
module axi2ahb_rdata #(
  parameter int AXI_ID_WIDTH   = 1,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  axi2ahb_rdata_if.slave    bus
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = AXI_ID_WIDTH + 3 + AXI_DATA_WIDTH;

  localparam logic [CNT_W-1:0] FULL_LEVEL  = CNT_W'(FIFO_DEPTH);
  // Two slots stay in reserve: one for the beat already in its data phase
  // and one for the address phase the control block may have just issued.
  localparam logic [CNT_W-1:0] READY_LEVEL = CNT_W'(FIFO_DEPTH - 2);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE     = PTR_W'(1);

  logic [ENTRY_W-1:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [CNT_W-1:0]          count;
  logic [CNT_W-1:0]          count_next;
  logic                      err_sticky;
  logic                      ready_q;
  logic                      overflow_q;

  logic                      capture;
  logic                      full;
  logic                      pop;
  logic                      push;
  logic                      drop;
  logic                      beat_err;
  logic [1:0]                beat_resp;
  logic [AXI_DATA_WIDTH-1:0] beat_data;
  logic [ENTRY_W-1:0]        beat_entry;
  logic [ENTRY_W-1:0]        head_entry;

  // Capture/pop decisions and the next occupancy. A beat arriving while the
  // buffer is full is still taken if the head leaves in the same cycle.
  always_comb begin
    capture    = bus.ctrl_rdata_valid_i && (bus.HREADY || bus.cmd_error_i);
    full       = (count == FULL_LEVEL);
    pop        = (count != '0) && bus.RREADY;
    push       = capture && (!full || pop);
    drop       = capture && full && !pop;
    beat_err   = bus.HRESP || bus.cmd_error_i;
    beat_resp  = (beat_err || err_sticky) ? 2'b10 : 2'b00;
    beat_data  = bus.cmd_error_i ? '0 : bus.HRDATA;
    beat_entry = {bus.cmd_id_i, beat_resp, bus.ctrl_rdata_last_i, beat_data};
    count_next = count;
    if (push && !pop) begin
      count_next = count + CNT_ONE;
    end else if (!push && pop) begin
      count_next = count - CNT_ONE;
    end
  end

  // Pointers, occupancy, the per-burst error flag and the registered
  // credit/overflow outputs. The error flag tracks the burst being captured,
  // so the final beat of a burst clears it for the next one.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      err_sticky <= 1'b0;
      ready_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count      <= count_next;
      ready_q    <= (count_next <= READY_LEVEL);
      overflow_q <= drop;
      if (capture) begin
        if (bus.ctrl_rdata_last_i) begin
          err_sticky <= 1'b0;
        end else if (beat_err) begin
          err_sticky <= 1'b1;
        end
      end
    end
  end

  // Beat storage needs no reset: the head is masked to zero whenever the
  // buffer is empty, which includes the whole reset period.
  always_ff @(posedge ACLK) begin
    if (push) begin
      mem[wr_ptr] <= beat_entry;
    end
  end

  assign head_entry = (count != '0) ? mem[rd_ptr] : '0;

  assign {bus.RID, bus.RRESP, bus.RLAST, bus.RDATA} = head_entry;
  assign bus.RVALID             = (count != '0);
  assign bus.ctrl_rdata_ready_o = ready_q;
  assign bus.overflow_o         = overflow_q;

endmodule

// File: tb/tb_axi2ahb_rdata.sv
// tb_axi2ahb_rdata
// Self-checking bench for axi2ahb_rdata. A queue of expected beats plus a
// per-burst error flag predicts the R channel, the credit output and the
// overflow pulse after every clock edge. Directed bursts cover the
// documented scenarios; a randomized phase then mixes traffic and back-pressure.
module tb_axi2ahb_rdata;

  localparam int IDW   = 2;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  typedef struct {
    logic [IDW-1:0] id;
    logic [1:0]     resp;
    logic           last;
    logic [DW-1:0]  data;
  } beat_t;

  logic ACLK    = 1'b0;
  logic ARESETN = 1'b0;

  axi2ahb_rdata_if #(.AXI_ID_WIDTH(IDW), .AXI_DATA_WIDTH(DW)) bus ();

  axi2ahb_rdata #(
    .AXI_ID_WIDTH  (IDW),
    .AXI_DATA_WIDTH(DW),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .ACLK   (ACLK),
    .ARESETN(ARESETN),
    .bus    (bus)
  );

  always #5 ACLK = ~ACLK;

  beat_t model_q[$];
  logic  model_sticky = 1'b0;
  logic  exp_overflow = 1'b0;
  int    check_count  = 0;
  int    error_count  = 0;

  // Single comparison point: counts every check, reports any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Compare all DUT outputs with the model's current prediction.
  task automatic checkAll();
    checkOutput("RVALID", 64'(bus.RVALID), 64'(model_q.size() != 0));
    checkOutput("ready", 64'(bus.ctrl_rdata_ready_o), 64'(model_q.size() <= DEPTH - 2));
    checkOutput("overflow", 64'(bus.overflow_o), 64'(exp_overflow));
    if (model_q.size() != 0) begin
      checkOutput("RDATA", 64'(bus.RDATA), 64'(model_q[0].data));
      checkOutput("RID", 64'(bus.RID), 64'(model_q[0].id));
      checkOutput("RRESP", 64'(bus.RRESP), 64'(model_q[0].resp));
      checkOutput("RLAST", 64'(bus.RLAST), 64'(model_q[0].last));
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model with
  // the same inputs, then check the outputs shortly after the edge.
  task automatic applyStimulus(input logic valid, input logic last, input logic hready,
                               input logic hresp, input logic err,
                               input logic [IDW-1:0] id, input logic [DW-1:0] data,
                               input logic rready);
    logic  cap;
    logic  do_pop;
    beat_t b;
    bus.ctrl_rdata_valid_i = valid;
    bus.ctrl_rdata_last_i  = last;
    bus.HREADY             = hready;
    bus.HRESP              = hresp;
    bus.cmd_error_i        = err;
    bus.cmd_id_i           = id;
    bus.HRDATA             = data;
    bus.RREADY             = rready;
    @(posedge ACLK);
    cap          = valid && (hready || err);
    do_pop       = (model_q.size() != 0) && rready;
    exp_overflow = 1'b0;
    if (do_pop) begin
      void'(model_q.pop_front());
    end
    if (cap) begin
      b.id   = id;
      b.resp = (hresp || err || model_sticky) ? 2'b10 : 2'b00;
      b.last = last;
      b.data = err ? '0 : data;
      if (last) begin
        model_sticky = 1'b0;
      end else if (hresp || err) begin
        model_sticky = 1'b1;
      end
      if (model_q.size() == DEPTH) begin
        exp_overflow = 1'b1;
      end else begin
        model_q.push_back(b);
      end
    end
    #1;
    checkAll();
  endtask

  task automatic idle(input logic rready);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0, rready);
  endtask

  task automatic beat(input logic last, input logic [IDW-1:0] id, input logic [DW-1:0] data,
                      input logic hresp, input logic rready);
    applyStimulus(1'b1, last, 1'b1, hresp, 1'b0, id, data, rready);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear at once.
  task automatic pulseReset();
    #1 ARESETN = 1'b0;
    #1;
    model_q.delete();
    model_sticky = 1'b0;
    exp_overflow = 1'b0;
    checkOutput("rst RVALID", 64'(bus.RVALID), 64'd0);
    checkOutput("rst ready", 64'(bus.ctrl_rdata_ready_o), 64'd1);
    checkOutput("rst overflow", 64'(bus.overflow_o), 64'd0);
    checkOutput("rst RDATA", 64'(bus.RDATA), 64'd0);
    #1 ARESETN = 1'b1;
  endtask

  initial begin
    bus.ctrl_rdata_valid_i = 1'b0;
    bus.ctrl_rdata_last_i  = 1'b0;
    bus.HREADY             = 1'b1;
    bus.HRESP              = 1'b0;
    bus.cmd_error_i        = 1'b0;
    bus.cmd_id_i           = '0;
    bus.HRDATA             = '0;
    bus.RREADY             = 1'b0;

    #12;
    $display("[TB] reset values");
    checkOutput("reset RVALID", 64'(bus.RVALID), 64'd0);
    checkOutput("reset ready", 64'(bus.ctrl_rdata_ready_o), 64'd1);
    checkOutput("reset overflow", 64'(bus.overflow_o), 64'd0);
    checkOutput("reset RDATA", 64'(bus.RDATA), 64'd0);
    ARESETN = 1'b1;
    idle(1'b1);

    $display("[TB] 4-beat OKAY burst");
    for (int i = 0; i < 4; i++) begin
      beat(i == 3, 2'd1, 32'hA0 + 32'(i), 1'b0, 1'b1);
    end
    idle(1'b1);
    idle(1'b1);

    $display("[TB] 16-beat stream under back-pressure, then drain");
    for (int i = 0; i < 16; i++) begin
      beat(i[1:0] == 2'd3, 2'(i), 32'h1000 + 32'(i), 1'b0, 1'b0);
    end
    for (int i = 0; i < 18; i++) begin
      idle(1'b1);
    end

    $display("[TB] error mid-burst, then clean burst");
    for (int i = 0; i < 4; i++) begin
      beat(i == 3, 2'd2, 32'hB0 + 32'(i), i == 1, 1'b1);
    end
    beat(1'b0, 2'd3, 32'hC0, 1'b0, 1'b1);
    beat(1'b1, 2'd3, 32'hC1, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    $display("[TB] rejected burst without AHB transfer");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 32'hDEAD_BEEF, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 32'hDEAD_BEEF, 1'b0);
    idle(1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
    end

    $display("[TB] overflow at full");
    for (int i = 0; i < 16; i++) begin
      beat(1'b1, 2'd0, 32'h2000 + 32'(i), 1'b0, 1'b0);
    end
    beat(1'b1, 2'd1, 32'h2EEE, 1'b0, 1'b0);
    idle(1'b0);
    beat(1'b1, 2'd2, 32'h2FFF, 1'b0, 1'b1);
    for (int i = 0; i < 18; i++) begin
      idle(1'b1);
    end

    $display("[TB] reset with beats buffered");
    for (int i = 0; i < 5; i++) begin
      beat(1'b0, 2'd1, 32'h3000 + 32'(i), i == 2, 1'b0);
    end
    pulseReset();
    idle(1'b0);
    beat(1'b1, 2'd2, 32'h4444, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    $display("[TB] randomized traffic");
    for (int seg = 0; seg < 4; seg++) begin
      int rready_pct;
      case (seg)
        0:       rready_pct = 30;
        1:       rready_pct = 55;
        2:       rready_pct = 90;
        default: rready_pct = 8;
      endcase
      for (int i = 0; i < 120; i++) begin
        applyStimulus($urandom_range(99) < 60,
                      $urandom_range(99) < 25,
                      $urandom_range(99) < 75,
                      $urandom_range(99) < 10,
                      $urandom_range(99) < 5,
                      IDW'($urandom),
                      $urandom,
                      $urandom_range(99) < rready_pct);
      end
    end
    for (int i = 0; i < DEPTH + 2; i++) begin
      idle(1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
